// File: rtl/jt7759_romsrv.sv
// jt7759_romsrv: two-line (current + prefetched) byte cache serving the JT7759 ROM port from a 16-bit variable-latency memory.
module jt7759_romsrv #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rom_cs,
  input  logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_ok,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_ok
);
  typedef enum logic [2:0] {IDLE, FILL0, FILL1, SWAP, PREF0, PREF1} st_t;
  st_t         r_st;
  logic [14:0] r_ctag, r_ntag, r_ltag;
  logic        r_cval, r_nval, r_req, r_drop, r_abort;
  logic [31:0] r_cdat, r_ndat;
  logic [15:0] r_addr;
  logic [14:0] w_tag, w_ptag;
  logic        w_chit, w_nhit, w_ack, w_pref, w_jmp, w_stop;
  assign w_tag    = rom_addr[16:2];
  assign w_ptag   = r_ctag + 15'd1;
  assign w_chit   = r_cval && r_ctag == w_tag;
  assign w_nhit   = r_nval && r_ntag == w_tag;
  assign w_ack    = mem_ok && r_req;
  assign w_pref   = r_st == PREF0 || r_st == PREF1;
  assign w_jmp    = rom_cs && !w_chit && w_tag != r_ltag;
  // a demand outside the prefetch line abandons the prefetch once its word lands
  assign w_stop   = flush || r_drop || (w_pref && (r_abort || w_jmp));
  assign rom_ok   = rom_cs && w_chit;
  assign rom_data = r_cdat[{rom_addr[1:0], 3'b000} +: 8];
  assign mem_req  = r_req;
  assign mem_addr = r_addr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= IDLE;
      r_ctag  <= '0;
      r_ntag  <= '0;
      r_ltag  <= '0;
      r_cval  <= 1'b0;
      r_nval  <= 1'b0;
      r_req   <= 1'b0;
      r_drop  <= 1'b0;
      r_abort <= 1'b0;
      r_cdat  <= '0;
      r_ndat  <= '0;
      r_addr  <= '0;
    end else begin
      r_drop  <= (r_st == IDLE || r_st == SWAP) ? 1'b0 : r_drop | flush;
      r_abort <= w_pref ? r_abort | w_jmp : 1'b0;
      case (r_st)
        IDLE:
          if (rom_cs && !w_chit) begin
            if (w_nhit) begin
              r_ctag <= r_ntag;
              r_cdat <= r_ndat;
              r_cval <= 1'b1;
              r_nval <= 1'b0;
              r_st   <= SWAP;
            end else begin
              r_ltag <= w_tag;
              r_addr <= {w_tag, 1'b0};
              r_req  <= 1'b1;
              r_cval <= 1'b0;
              r_st   <= FILL0;
            end
          end else if (PREFETCH && rom_ok && !(r_nval && r_ntag == w_ptag)) begin
            r_ltag <= w_ptag;
            r_addr <= {w_ptag, 1'b0};
            r_req  <= 1'b1;
            r_nval <= 1'b0;
            r_st   <= PREF0;
          end
        FILL0, PREF0:
          if (w_ack) begin
            if (r_st == FILL0) r_cdat[15:0] <= mem_data;
            else r_ndat[15:0] <= mem_data;
            r_addr[0] <= 1'b1;
            r_req     <= !w_stop;
            r_st      <= w_stop ? IDLE : (r_st == FILL0 ? FILL1 : PREF1);
          end
        FILL1:
          if (w_ack) begin
            r_req <= 1'b0;
            r_st  <= IDLE;
            if (!w_stop) begin
              r_cdat[31:16] <= mem_data;
              r_ctag        <= r_ltag;
              r_cval        <= 1'b1;
            end
          end
        PREF1:
          if (w_ack) begin
            r_req <= 1'b0;
            r_st  <= IDLE;
            if (!w_stop && rom_cs && !w_chit) begin
              r_cdat <= {mem_data, r_ndat[15:0]};
              r_ctag <= r_ltag;
              r_cval <= 1'b1;
              r_st   <= SWAP;
            end else if (!w_stop) begin
              r_ndat[31:16] <= mem_data;
              r_ntag        <= r_ltag;
              r_nval        <= 1'b1;
            end
          end
        SWAP: r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
      if (flush) begin
        r_cval <= 1'b0;
        r_nval <= 1'b0;
      end
    end
  end
endmodule

// File: doc/jt7759_romsrv.md
Name: jt7759_romsrv

Overview:
- Responder for the JT7759 sample-ROM read port. It serves the byte requests issued by the JT7759 command/playback controller (rom_cs, rom_addr, rom_data, rom_ok) from an external 16-bit memory port such as SDRAM, which has variable latency.
- Holds two 4-byte line buffers: a current line and a prefetched next line. Sequential nibble playback therefore hits without waiting for memory.
- Sits between jt7759 top level and the core's memory arbiter.

Parameters:
- PREFETCH, 1, when 1 the next sequential line is fetched automatically after a demand fill; when 0 only demand fetches occur.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  invalidate both line buffers (e.g. ROM reload)
- rom_cs  input  1  controller read request, level
- rom_addr  input  17  byte address
- rom_data  output  8  byte for rom_addr
- rom_ok  output  1  rom_data valid for current rom_addr
- mem_req  output  1  memory request, level
- mem_addr  output  16  word address (byte address bits 16:1)
- mem_data  input  16  read word, little-endian (bits 7:0 = even byte)
- mem_ok  input  1  one-cycle pulse: mem_data valid for mem_addr

Behaviour:
- Line = 4 bytes, tag = addr[16:2]. Buffers: cur{tag,valid,data[31:0]} and nxt{tag,valid,data[31:0]}.
- rom_ok is combinational: rom_cs & cur.valid & cur.tag==rom_addr[16:2]. It drops in the same cycle that rom_addr leaves the line or rom_cs falls.
- rom_data is combinational: byte rom_addr[1:0] of cur.data. It is don't-care when rom_ok=0, but must be a deterministic value, never X.
- Reset values: rom_data=0, rom_ok=0, mem_req=0, mem_addr=0, both valids=0, FSM=IDLE.
- FSM states: IDLE, FILL0, FILL1, SWAP, PREF0, PREF1.
- IDLE, rom_cs high, cur miss, nxt hit -> SWAP.
- IDLE, rom_cs high, cur miss, nxt miss -> FILL0. Latch line tag, drive mem_addr={tag,1'b0}, mem_req=1.
- IDLE, cur hit, PREFETCH=1, nxt invalid or nxt.tag!=cur.tag+1 -> PREF0 with tag cur.tag+1. The tag wraps from 0x7FFF to 0x0000.
- FILL0: on mem_ok store word into data[15:0], set mem_addr LSB=1 the next cycle, go to FILL1. mem_req stays high.
- FILL1: on mem_ok store data[31:16], cur.valid=1, cur.tag=latched tag, mem_req=0, go to IDLE.
- SWAP: one cycle. cur<=nxt, nxt.valid<=0, then IDLE. Hit latency after a swap is 1 cycle.
- PREF0/PREF1: same as FILL0/FILL1 but fill nxt.
- Demand miss during prefetch (rom_cs high, cur miss):
  - if the address is in the prefetch line, finish PREF1 then SWAP;
  - otherwise finish the word currently requested, abandon the rest of the prefetch (nxt.valid=0, mem_req low for one cycle), then FILL0.
- Memory handshake rules:
  - mem_addr is stable while mem_req=1 until mem_ok.
  - A request is never withdrawn before its mem_ok.
  - mem_ok while mem_req=0 is ignored.
- Address change during FILL: the fill completes into cur with the latched tag; IDLE then re-evaluates hit or miss against the new rom_addr.
- rom_cs low does not cancel an in-flight line fill.
- flush:
  - both valids are cleared in the same cycle;
  - an in-flight transaction still completes its current word; the line it was filling is discarded (valid not set) and the FSM returns to IDLE;
  - flush takes priority over a simultaneous fill completion.
- Minimum miss latency: 2 cycles + 2 memory latencies. Hit-to-hit within a line: 0 cycles.
- Reset mid-fetch: everything returns to reset values immediately. A stray later mem_ok is ignored.

Test Plan:
- Cold read: rom_cs=1, rom_addr=0x00005. mem returns 0x2211 @word 2 and 0x4433 @word 3, 3-cycle latency each. Required: mem_addr 0x0002 then 0x0003, then rom_ok=1 with rom_data=0x22. Addresses 4, 6, 7 then give 0x11, 0x33, 0x44 with rom_ok in the same cycle.
- Prefetch/swap: PREFETCH=1. After the line-1 fill, required mem_addr 0x0004/0x0005 without any rom_cs change. Moving rom_addr to 0x00008 gives rom_ok=0 for 1 cycle (SWAP), then 1, with no new mem_req.
- Wrap: read addr 0x1FFFC. Prefetch requests mem_addr 0x0000/0x0001. A subsequent read of addr 0 hits after SWAP.
- Jump during prefetch: while PREF0 waits, rom_addr=0x10000. Required: PREF0 word completes, mem_req low 1 cycle, then fill at mem_addr 0x8000/0x8001. nxt.valid=0 afterwards.
- Flush mid-fill: assert flush during FILL1 with mem_ok in the same cycle. Required: cur invalid, rom_ok=0, and a new FILL0 for the same address starts.
- Reset: assert rst during FILL0, then deliver mem_ok after reset release. Required: all outputs 0, no valid line, no state change.
